// File: rtl/switch_debounce_bank.sv
// Bank of WIDTH switch inputs: two-flop synchroniser, per-channel debounce counter,
// edge pulses, LED drive and a single-entry change event with valid/ack handshake.
module switch_debounce_bank #(
  parameter int WIDTH          = 8,
  parameter int DB_CYCLES      = 16,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SWICH,
  output logic [WIDTH-1:0] STATE,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] LED,
  output logic             EVT_VALID,
  output logic [WIDTH-1:0] EVT_DATA,
  output logic             EVT_OVF,
  input  logic             EVT_ACK
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] upd;
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             any_upd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SWICH;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CW-1:0] cnt_q, cnt_d;
      logic          differ;
      logic          hit;

      assign differ       = sync2_q[gi] ^ state_q[gi];
      assign hit          = differ && (cnt_q == CNT_MAX);
      assign upd[gi]      = hit;
      assign state_d[gi]  = hit ? sync2_q[gi] : state_q[gi];

      // Any return to the accepted level restarts the stability window.
      always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!differ || hit) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign any_upd = |upd;
  assign rise_d  = upd & state_d;
  assign fall_d  = upd & ~state_d;

  // New change always overwrites the snapshot; overflow flags only an unacked overwrite.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_ovf_d   = evt_ovf_q;
    if (any_upd) begin
      evt_valid_d = 1'b1;
      evt_data_d  = state_d;
      evt_ovf_d   = evt_valid_q && !EVT_ACK;
    end else if (evt_valid_q && EVT_ACK) begin
      evt_valid_d = 1'b0;
      evt_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign STATE     = state_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign LED       = (LED_ACTIVE_LOW != 0) ? ~state_q : state_q;
  assign EVT_VALID = evt_valid_q;
  assign EVT_DATA  = evt_data_q;
  assign EVT_OVF   = evt_ovf_q;

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Scoreboarded bench: directed scenarios plus random switch activity, checked every
// cycle against a window-based reference model of the debounced bank.
module tb_switch_debounce_bank;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EVT_ACK = 1'b0;
  logic [W-1:0] SWICH = '0;

  logic [W-1:0] STATE, RISE, FALL, LED, EVT_DATA;
  logic         EVT_VALID, EVT_OVF;
  logic [3:0]   state2, rise2, fall2, led2, evt_data2;
  logic         evt_valid2, evt_ovf2;

  always #5 CLK = ~CLK;

  switch_debounce_bank #(.WIDTH(W), .DB_CYCLES(DB), .LED_ACTIVE_LOW(1)) dut (
    .CLK(CLK), .RST(RST), .SWICH(SWICH),
    .STATE(STATE), .RISE(RISE), .FALL(FALL), .LED(LED),
    .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA), .EVT_OVF(EVT_OVF),
    .EVT_ACK(EVT_ACK)
  );

  switch_debounce_bank #(.WIDTH(4), .DB_CYCLES(DB), .LED_ACTIVE_LOW(0)) dut_hi (
    .CLK(CLK), .RST(RST), .SWICH(SWICH[3:0]),
    .STATE(state2), .RISE(rise2), .FALL(fall2), .LED(led2),
    .EVT_VALID(evt_valid2), .EVT_DATA(evt_data2), .EVT_OVF(evt_ovf2),
    .EVT_ACK(EVT_ACK)
  );

  typedef struct packed {
    logic [W-1:0] state;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] led;
    logic         valid;
    logic [W-1:0] data;
    logic         ovf;
    logic [3:0]   state2;
    logic [3:0]   led2;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  // Reference model: a channel accepts a new level once the last DB synchronised
  // samples all disagree with the accepted level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_data = '0;
  logic         m_valid = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] hist[$];

  task automatic step(input logic [W-1:0] sw, input logic rst, input logic ack);
    exp_t         e;
    logic [W-1:0] upd, nstate;
    bit           all_diff;
    SWICH   = sw;
    RST     = rst;
    EVT_ACK = ack;
    upd     = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_data = '0;
      m_valid = 1'b0; m_ovf = 1'b0;
      hist.delete();
      hist.push_back('0);
    end else begin
      if (hist.size() == DB) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++) if (hist[k][b] == m_state[b]) all_diff = 1'b0;
          upd[b] = all_diff;
        end
      end
      nstate = m_state ^ upd;
      if (|upd) begin
        m_ovf   = m_valid && !ack;
        m_valid = 1'b1;
        m_data  = nstate;
      end else if (m_valid && ack) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end
      m_state = nstate;
      m_s2 = m_s1;
      m_s1 = sw;
      hist.push_back(m_s2);
      if (hist.size() > DB) void'(hist.pop_front());
    end
    e.state  = m_state;
    e.rise   = upd & m_state;
    e.fall   = upd & ~m_state;
    e.led    = ~m_state;
    e.valid  = m_valid;
    e.data   = m_data;
    e.ovf    = m_ovf;
    e.state2 = m_state[3:0];
    e.led2   = m_state[3:0];
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [W-1:0] sw, input int n);
    for (int i = 0; i < n; i++) step(sw, 1'b0, 1'b0);
  endtask

  exp_t mon_exp, mon_act;
  always @(negedge CLK) begin
    cycle++;
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_act = '{STATE, RISE, FALL, LED, EVT_VALID, EVT_DATA, EVT_OVF, state2, led2};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got state=%h rise=%h fall=%h led=%h v=%b d=%h ovf=%b s2=%h l2=%h, need state=%h rise=%h fall=%h led=%h v=%b d=%h ovf=%b s2=%h l2=%h",
                 cycle, mon_act.state, mon_act.rise, mon_act.fall, mon_act.led, mon_act.valid,
                 mon_act.data, mon_act.ovf, mon_act.state2, mon_act.led2,
                 mon_exp.state, mon_exp.rise, mon_exp.fall, mon_exp.led, mon_exp.valid,
                 mon_exp.data, mon_exp.ovf, mon_exp.state2, mon_exp.led2);
      end
    end
  end

  initial begin
    logic [W-1:0] sw;
    // Switches held high across reset, then debounced rise and event.
    for (int i = 0; i < 3; i++) step(8'hA5, 1'b1, 1'b0);
    hold(8'hA5, 10);
    step(8'hA5, 1'b0, 1'b1);
    hold(8'hA5, 3);
    // Return to zero, acknowledge, then bounce channel 0 with 3-cycle pulses.
    hold(8'h00, 10);
    step(8'h00, 1'b0, 1'b1);
    hold(8'h00, 2);
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 8'h01 : 8'h00, 3);
    hold(8'h00, 6);
    // Fall latency from STATE=01.
    hold(8'h01, 10);
    step(8'h01, 1'b0, 1'b1);
    hold(8'h00, 10);
    step(8'h00, 1'b0, 1'b1);
    hold(8'h00, 2);
    // Overflow: two changes while the first event is still pending.
    hold(8'h08, 8);
    hold(8'h18, 8);
    step(8'h18, 1'b0, 1'b1);
    hold(8'h18, 3);
    // Ack colliding with the update edge of a new change.
    hold(8'h01, 8);
    hold(8'h09, DB + 1);
    step(8'h09, 1'b0, 1'b1);
    hold(8'h09, 4);
    step(8'h09, 1'b0, 1'b1);
    hold(8'h09, 2);
    // Random activity: sparse bit flips, random acks, occasional reset.
    sw = 8'h09;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) sw[$urandom_range(0, W - 1)] ^= 1'b1;
      step(sw, ($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0));
    end
    hold(sw, 10);
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, need 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce_bank.md
# switch_debounce_bank

Parametrised bank of debounced switch inputs for the demo boards, replacing the direct switch-to-LED wiring with a properly conditioned path. Each of WIDTH asynchronous switch lines is synchronised, debounced with a per-channel counter, and exposed as a stable level, single-cycle rise/fall pulses, an LED drive of selectable polarity and a snapshot event with a valid/ack handshake. It sits between the board switch pins and any consumer logic (LED bank, mode select, menu FSMs).

## Interface
- WIDTH, 8: number of switch channels, ≥1.
- DB_CYCLES, 16: consecutive stable cycles required to accept a new level, ≥2.
- LED_ACTIVE_LOW, 1: 1 → LED = ~STATE; 0 → LED = STATE.
- CLK  input  1  system clock; single clock domain.
- RST  input  1  reset; synchronous, active-high.
- SWICH  input  WIDTH  raw asynchronous switch levels.
- STATE  output  WIDTH  debounced switch levels.
- RISE  output  WIDTH  one-cycle pulse per channel when STATE bit goes 0→1.
- FALL  output  WIDTH  one-cycle pulse per channel when STATE bit goes 1→0.
- LED  output  WIDTH  LED drive derived from STATE per LED_ACTIVE_LOW.
- EVT_VALID  output  1  a STATE change snapshot is pending.
- EVT_DATA  output  WIDTH  STATE value captured at the most recent change.
- EVT_OVF  output  1  a further change occurred while EVT_VALID was pending.
- EVT_ACK  input  1  consumer accepts the pending event.

## Operation
- Synchroniser: two flops per channel (sync1 ← SWICH, sync2 ← sync1). No logic on sync1.
- Debounce per channel, counter width $clog2(DB_CYCLES):
  - sync2 == STATE bit → counter ← 0.
  - sync2 != STATE bit and counter < DB_CYCLES−1 → counter +1.
  - sync2 != STATE bit and counter == DB_CYCLES−1 → STATE bit ← sync2, counter ← 0, "update" for that channel.
  - Any bounce back to STATE value restarts the count from 0; no saturation or wrap beyond DB_CYCLES−1.
- RISE/FALL registered: asserted in the same cycle STATE shows the new value, for exactly one cycle; RISE = update & new 1, FALL = update & new 0. Multiple channels may pulse together.
- LED registered-equivalent: pure function of STATE, no additional latency.
- Event handshake (any = OR of channel updates, computed from the post-update STATE value):
  - any & !EVT_VALID → EVT_VALID ← 1, EVT_DATA ← new STATE, EVT_OVF ← 0.
  - any & EVT_VALID & !EVT_ACK → EVT_DATA ← new STATE (latest wins), EVT_OVF ← 1.
  - any & EVT_VALID & EVT_ACK → EVT_VALID stays 1, EVT_DATA ← new STATE, EVT_OVF ← 0.
  - !any & EVT_VALID & EVT_ACK → EVT_VALID ← 0, EVT_OVF ← 0; EVT_DATA holds.
  - EVT_ACK while EVT_VALID=0 ignored.
- Reset (RST high at a CLK edge): sync flops, STATE, counters, RISE, FALL, EVT_VALID, EVT_DATA, EVT_OVF ← 0; LED ← all ones if LED_ACTIVE_LOW else all zeros. Reset mid-debounce discards the count. Switches held high across reset produce a normal debounced rise and event after release of reset.

## Timing
- SWICH change set up before edge E0: sync2 holds it after E1; STATE, RISE/FALL, LED update after edge E0+DB_CYCLES+1 (DB_CYCLES+2 edges total) provided the input stays constant.
- EVT_VALID/EVT_DATA update in the same cycle as STATE.
- EVT_VALID drops the cycle after the ack edge; minimum one cycle between accepted events.
- Glitches shorter than DB_CYCLES cycles at sync2 never reach STATE.

## Test plan
- Reset: hold RST 3 cycles with SWICH=8'hA5 → all outputs 0, LED=8'hFF; release, after 6 edges (DB_CYCLES=4) STATE=8'hA5, RISE=8'hA5 for one cycle, LED=8'h5A, EVT_VALID=1, EVT_DATA=8'hA5.
- Bounce reject: toggle SWICH[0] every 3 cycles for 30 cycles from STATE=0 → STATE[0], RISE[0] stay 0, no event.
- Fall latency: STATE=8'h01, set SWICH=0 → FALL[0] pulses exactly on edge 6, STATE=0.
- Overflow: event pending, no ack, change SWICH[3] then SWICH[4] → EVT_DATA tracks latest STATE, EVT_OVF=1; ack → EVT_VALID, EVT_OVF 0 next cycle.
- Ack collision: ack asserted on the same edge as a new change → EVT_VALID stays 1, EVT_DATA=new STATE, EVT_OVF=0.
- Polarity: LED_ACTIVE_LOW=0, WIDTH=4, SWICH=4'h9 debounced → LED=4'h9.
